// File: rtl/pulpino_qsys_test.sv
// pulpino_qsys_test: board bring-up top showing tick-paced test patterns on LEDR.
// Optional LED_HEARTBEAT_EN: LEDR[9] toggles every tick; when undefined LEDR[9] is 0.
module pulpino_qsys_test #(
  parameter int TICK_DIV = 5000
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR
);

  localparam int CW = $clog2(TICK_DIV);

  logic          key_rst_n;
  logic [1:0]    rst_sync_reg;
  logic          rst_n;
  logic          unused_key;
  logic [9:0]    sw_meta_reg;
  logic [9:0]    sw_sync_reg;
  logic [CW-1:0] tick_cnt_reg;
  logic          tick;
  logic [8:0]    cnt_reg;
  logic [8:0]    walk_reg;
  logic [8:0]    walk_rot;
  logic [8:0]    bnc_reg;
  logic [8:0]    bnc_next;
  logic          dir_left_reg;
  logic          dir_left_next;
  logic [8:0]    led_reg;
  logic [8:0]    led_next;

  assign key_rst_n  = KEY[0];
  assign unused_key = ^KEY[3:1];

  // Reset asserts immediately with KEY[0], releases two clocks after KEY[0] rises.
  always_ff @(posedge CLOCK_50 or negedge key_rst_n) begin
    if (!key_rst_n) rst_sync_reg <= 2'b00;
    else            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n = rst_sync_reg[1];

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      sw_meta_reg <= SW;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  assign tick = (tick_cnt_reg == CW'(TICK_DIV - 1));

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n)    tick_cnt_reg <= '0;
    else if (tick) tick_cnt_reg <= '0;
    else           tick_cnt_reg <= tick_cnt_reg + CW'(1);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_walk_rot
      assign walk_rot[gi] = walk_reg[(gi + 8) % 9];
    end
  endgenerate

  // The bounce direction flips as soon as an end is reached, so each end shows for one tick.
  always_comb begin
    bnc_next      = bnc_reg;
    dir_left_next = dir_left_reg;
    if (tick) begin
      bnc_next = dir_left_reg ? {bnc_reg[7:0], 1'b0} : {1'b0, bnc_reg[8:1]};
      if (bnc_next[8])      dir_left_next = 1'b0;
      else if (bnc_next[0]) dir_left_next = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      walk_reg     <= 9'b000000001;
      bnc_reg      <= 9'b000000001;
      dir_left_reg <= 1'b1;
    end else begin
      if (tick) begin
        cnt_reg  <= cnt_reg + 9'd1;
        walk_reg <= walk_rot;
      end
      bnc_reg      <= bnc_next;
      dir_left_reg <= dir_left_next;
    end
  end

  always_comb begin
    led_next = cnt_reg;
    case (sw_sync_reg[1:0])
      2'b00:   led_next = cnt_reg;
      2'b01:   led_next = walk_reg;
      2'b10:   led_next = bnc_reg;
      default: led_next = {1'b0, sw_sync_reg[9:2]};
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) led_reg <= '0;
    else        led_reg <= led_next;
  end

`ifdef LED_HEARTBEAT_EN
  logic hb_reg;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n)    hb_reg <= 1'b0;
    else if (tick) hb_reg <= ~hb_reg;
  end

  assign LEDR = {hb_reg, led_reg};
`else
  assign LEDR = {1'b0, led_reg};
`endif

endmodule

// File: tb/tb_pulpino_qsys_test.sv
// Self-checking bench for pulpino_qsys_test: random switch stimulus against a tick-count model.
module tb_pulpino_qsys_test;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic [3:0] key;
  logic [9:0] sw;
  logic [9:0] ledr;

  int n_cmp = 0;
  int n_bad = 0;
  int e     = 0;

  logic [9:0] sw_hist [0:8191];

  always #10 clk = ~clk;

  pulpino_qsys_test #(.TICK_DIV(TD)) dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .SW      (sw),
    .LEDR    (ledr)
  );

  task automatic check_val(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, e);
    end
  endtask

  // Number of ticks completed once the given post-release edge has happened.
  function automatic int ticks_after(input int edge_n);
    return (edge_n < 2) ? 0 : (edge_n - 2) / TD;
  endfunction

  function automatic logic [9:0] model_led(input int edge_n);
    logic [8:0] lo;
    logic [9:0] src;
    logic       hb;
    int         g;
    int         p;
    lo = '0;
    hb = 1'b0;
    if (edge_n >= 3) begin
      src = (edge_n >= 5) ? sw_hist[edge_n-2] : 10'd0;
      g   = ticks_after(edge_n - 1);
      case (src[1:0])
        2'b00: lo = 9'(g % 512);
        2'b01: lo = 9'd1 << (g % 9);
        2'b10: begin
          p = g % 16;
          if (p > 8) p = 16 - p;
          lo = 9'd1 << p;
        end
        default: lo = {1'b0, src[9:2]};
      endcase
    end
`ifdef LED_HEARTBEAT_EN
    hb = ((ticks_after(edge_n) % 2) == 1);
`endif
    return {hb, lo};
  endfunction

  task automatic step(input string tag);
    @(posedge clk);
    if (e < 8191) e++;
    sw_hist[e] = sw;
    @(negedge clk);
    check_val(tag, ledr, model_led(e));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #3;
    key[0] = 1'b0;
    #1;
    check_val("async_rst", ledr, 10'h000);
    repeat (3) @(negedge clk);
    check_val("rst_hold", ledr, 10'h000);
    key[0] = 1'b1;
    e = 0;
  endtask

  initial begin
    key = 4'b1111;
    sw  = 10'd0;
    #5;
    key = 4'b1110;
    #10;
    check_val("rst_init", ledr, 10'h000);
    apply_reset();

    // Counter mode: first tick, then nine ticks total.
    for (int i = 0; i < TD + 2; i++) step("cnt");
    check_val("pre_tick", ledr & 10'h1FF, 10'h000);
    step("cnt");
    check_val("first_tick", {1'b0, ledr[8:0]}, 10'h001);
    repeat (8 * TD) step("cnt");
    check_val("cnt_9", {1'b0, ledr[8:0]}, 10'h009);

    sw = 10'b0000000001;
    repeat (10 * TD) step("walk");
    sw = 10'b0000000010;
    repeat (20 * TD) step("bnc");

    sw = 10'b1010101011;
    repeat (3) step("mirror_lat");
    check_val("mirror", {1'b0, ledr[8:0]}, 10'h0AA);

    sw = 10'd0;
    repeat (3) step("mode_sw");
    check_val("bg_cnt", {1'b0, ledr[8:0]}, 10'(ticks_after(e - 1) % 512));

    for (int i = 0; i < 2400; i++) begin
      if ($urandom_range(0, 39) == 0) sw = 10'($urandom);
      step("rand");
    end

    sw = 10'd0;
    repeat (5) step("pre_rst");
    key[3:1] = 3'($urandom);
    apply_reset();
    for (int i = 0; i < TD + 3; i++) step("restart");
    check_val("restart_cnt", {1'b0, ledr[8:0]}, 10'h001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
